alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control unit for the multicycle datapath.
- Decodes the 2-bit ALUOp from main control and the 6-bit Funct field into the ALU control word.
- Sequences iterative multiply/divide operations: issues a start pulse, counts the iterations, and stalls upstream until the operation completes.
- Sits between the main control FSM and the ALU / mult-div unit.

Parameters:
- DATA_W, 32, datapath width; sets the mult/div iteration count.
- CTRL_W, 4, width of the ALU control word; must be >= 4, with upper bits zero-padded.
- MD_CYCLES, DATA_W, number of busy cycles for a mult/div operation; minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  ALUOp/Funct valid this cycle.
- ALUOp  input  2  operation class from main control.
- Funct  input  6  instruction funct field.
- ready  output  1  unit can accept valid_in; low during a mult/div operation.
- alu_ctrl  output  CTRL_W  registered ALU control word {ainv, binv, op[1:0]}.
- ctrl_valid  output  1  one-cycle pulse: alu_ctrl updated.
- illegal  output  1  one-cycle pulse, coincident with ctrl_valid: undecodable op.
- md_start  output  1  one-cycle pulse to the mult/div unit.
- md_op  output  2  00 mult, 01 multu, 10 div, 11 divu; held for the whole operation.
- md_done  output  1  one-cycle pulse at the end of the operation.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, counter=0.
  - alu_ctrl=0, md_op=0.
  - ready=1.
  - ctrl_valid, illegal, md_start, md_done all 0.
  - Reset mid-operation aborts it; md_done is not emitted.
- Decode (combinational, registered on accept):
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 11 -> illegal.
  - ALUOp 10 with Funct:
    - 100000 -> 0010.
    - 100010 -> 0110.
    - 100100 -> 0000.
    - 100101 -> 0001.
    - 101010 -> 0111.
    - 100111 -> 1100 (nor).
    - 011000..011011 -> mult/div, md_op = Funct[1:0].
    - Any other Funct -> illegal.
- Accept = valid_in & ready.
- States:
  - IDLE: ready=1.
    - On accept of a single-cycle or illegal op: next edge loads alu_ctrl (0000 if illegal) and pulses ctrl_valid (and illegal if applicable); remain IDLE. Latency 1 cycle; back-to-back accepts every cycle are allowed.
    - On accept of a mult/div op: next edge sets md_start=1, md_op, counter=0, ctrl_valid=1 with alu_ctrl unchanged; go to MD_RUN.
  - MD_RUN: ready=0.
    - counter increments each cycle.
    - When counter==MD_CYCLES-1: next edge pulses md_done and returns to IDLE.
    - valid_in is ignored, not queued.
- Total ready-low time: exactly MD_CYCLES cycles, starting the cycle after accept.
- counter width: $clog2(MD_CYCLES+1); no wrap is possible.
- alu_ctrl holds its value between updates; it is never X after reset.
- Inputs are sampled only on accept; changes while ready=0 have no effect.

Optional Feature:
- Macro: ALU_CTRL_SHIFT_EN.
- Defined: ALUOp 10 with Funct 000000/000010/000011 (sll/srl/sra) decodes to 1000/1001/1010 as single-cycle ops.
- Undefined: those Funct values are illegal (alu_ctrl=0000, illegal pulse).
- No other behaviour changes.

Test Plan:
- Reset held 2 cycles, then released -> alu_ctrl=0, ready=1, all pulse outputs 0.
- ALUOp=10, Funct=101010, valid 1 cycle -> next cycle alu_ctrl=0111, ctrl_valid=1 for one cycle, illegal=0.
- Back-to-back accepts ALUOp=00, 01, then 10/100111 -> alu_ctrl 0010, 0110, 1100 on consecutive cycles, ctrl_valid high 3 cycles.
- ALUOp=10, Funct=011010, MD_CYCLES=32 -> md_start pulse with md_op=10; ready low exactly 32 cycles; md_done pulse at the end; a valid_in issued mid-operation is dropped.
- ALUOp=11, and ALUOp=10/Funct=000000 without the macro -> alu_ctrl=0000, illegal pulse; with ALU_CTRL_SHIFT_EN, Funct=000011 -> alu_ctrl=1010, no illegal pulse.
- reset asserted at counter=10 during a divide -> next cycle IDLE, ready=1, md_done never pulses.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control unit: registered ALUOp/Funct decode plus a mult/div sequencer that stalls upstream.
// Optional macro ALU_CTRL_SHIFT_EN adds sll/srl/sra decodes; without it those Funct codes are illegal.
module alu_ctrl_seq #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    output logic              ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_done
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MD_RUN = 1'b1
    } state_e;

    // Handshake: a request is taken on a rising edge where valid_in & ready are both high.
    // ready drops for exactly MD_CYCLES cycles after a mult/div is taken; valid_in is ignored then.

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        md_op_q, md_op_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              illegal_q, illegal_d;
    logic              md_start_q, md_start_d;
    logic              md_done_q, md_done_d;

    logic       accept;
    logic [3:0] dec_op;
    logic       dec_illegal;
    logic       dec_md;

    always_comb begin
        dec_op      = 4'b0000;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        case (ALUOp)
            2'b00: dec_op = 4'b0010;
            2'b01: dec_op = 4'b0110;
            2'b10: begin
                case (Funct)
                    6'b100000: dec_op = 4'b0010;
                    6'b100010: dec_op = 4'b0110;
                    6'b100100: dec_op = 4'b0000;
                    6'b100101: dec_op = 4'b0001;
                    6'b101010: dec_op = 4'b0111;
                    6'b100111: dec_op = 4'b1100;
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: dec_md = 1'b1;
`ifdef ALU_CTRL_SHIFT_EN
                    6'b000000: dec_op = 4'b1000;
                    6'b000010: dec_op = 4'b1001;
                    6'b000011: dec_op = 4'b1010;
`endif
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign accept = valid_in & ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        md_op_d      = md_op_q;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        md_start_d   = 1'b0;
        md_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctrl_valid_d = 1'b1;
                    if (dec_md) begin
                        // alu_ctrl is left alone so the ALU keeps its last setting during mult/div
                        md_start_d = 1'b1;
                        md_op_d    = Funct[1:0];
                        cnt_d      = '0;
                        state_d    = MD_RUN;
                    end else begin
                        alu_ctrl_d = dec_illegal ? '0 : CTRL_W'(dec_op);
                        illegal_d  = dec_illegal;
                    end
                end
            end
            MD_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    md_done_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= '0;
            md_op_q      <= 2'b00;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            md_start_q   <= 1'b0;
            md_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            md_op_q      <= md_op_d;
            ctrl_valid_q <= ctrl_valid_d;
            illegal_q    <= illegal_d;
            md_start_q   <= md_start_d;
            md_done_q    <= md_done_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign alu_ctrl   = alu_ctrl_q;
    assign md_op      = md_op_q;
    assign ctrl_valid = ctrl_valid_q;
    assign illegal    = illegal_q;
    assign md_start   = md_start_q;
    assign md_done    = md_done_q;

`ifndef SYNTHESIS
    a_illegal_with_valid: assert property (@(posedge clk) disable iff (reset)
        illegal_q |-> ctrl_valid_q);
    a_start_with_valid: assert property (@(posedge clk) disable iff (reset)
        md_start_q |-> ctrl_valid_q);
    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        cnt_q <= CNT_LAST);
    a_start_not_illegal: assert property (@(posedge clk) disable iff (reset)
        md_start_q |-> !illegal_q);
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode scoreboard, mult/div stall timing, reset abort.
module tb_alu_ctrl_seq;
    localparam int MD_CYCLES = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [1:0] ALUOp = 2'b00;
    logic [5:0] Funct = 6'b000000;
    logic       ready;
    logic [3:0] alu_ctrl;
    logic       ctrl_valid;
    logic       illegal;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_done;

    alu_ctrl_seq #(.DATA_W(32), .CTRL_W(4), .MD_CYCLES(MD_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .ready      (ready),
        .alu_ctrl   (alu_ctrl),
        .ctrl_valid (ctrl_valid),
        .illegal    (illegal),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_done    (md_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int md_done_cnt = 0;
    int exp_done = 0;
    logic [7:0] exp_q[$];
    logic [3:0] m_alu = 4'b0000;
    logic [1:0] m_mdop = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // expected word: {illegal, alu_ctrl[3:0], md_start, md_op[1:0]}
    task automatic push_exp(input logic [1:0] a, input logic [5:0] f);
        logic [3:0] op;
        logic       ill;
        logic       md;
        op = 4'b0000; ill = 1'b0; md = 1'b0;
        case (a)
            2'b00: op = 4'b0010;
            2'b01: op = 4'b0110;
            2'b11: ill = 1'b1;
            default: begin
                case (f)
                    6'b100000: op = 4'b0010;
                    6'b100010: op = 4'b0110;
                    6'b100100: op = 4'b0000;
                    6'b100101: op = 4'b0001;
                    6'b101010: op = 4'b0111;
                    6'b100111: op = 4'b1100;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
`ifdef ALU_CTRL_SHIFT_EN
                    6'b000000: op = 4'b1000;
                    6'b000010: op = 4'b1001;
                    6'b000011: op = 4'b1010;
`endif
                    default: ill = 1'b1;
                endcase
            end
        endcase
        if (md) begin
            m_mdop = f[1:0];
            exp_q.push_back({1'b0, m_alu, 1'b1, m_mdop});
        end else begin
            m_alu = ill ? 4'b0000 : op;
            exp_q.push_back({ill, m_alu, 1'b0, m_mdop});
        end
    endtask

    // driver: hold one request across the next rising edge (caller is aligned at posedge+1)
    task automatic issue(input logic [1:0] a, input logic [5:0] f);
        valid_in = 1'b1;
        ALUOp    = a;
        Funct    = f;
        push_exp(a, f);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic [5:0] f, input int inject_at);
        int low;
        issue(2'b10, f);
        valid_in = 1'b0;
        low = 0;
        for (int i = 0; i < MD_CYCLES + 20; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
            check("md_op_hold", {30'd0, md_op}, {30'd0, m_mdop});
            if (low == inject_at) begin
                valid_in = 1'b1;
                ALUOp    = 2'b00;
                Funct    = 6'($urandom_range(0, 63));
            end else begin
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        check("ready_low_cycles", low, MD_CYCLES);
        check("md_done_at_end", {31'd0, md_done}, 32'd1);
        exp_done++;
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (md_done) md_done_cnt++;
            if (ctrl_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
                end else begin
                    check("decode", {24'd0, illegal, alu_ctrl, md_start, md_op},
                          {24'd0, exp_q.pop_front()});
                end
            end else if (illegal || md_start) begin
                check("stray_pulse", {30'd0, illegal, md_start}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [5:0] funct_tbl [8];

    initial begin
        logic [1:0] a;
        logic [5:0] f;
        int low;
        funct_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b101010, 6'b100111, 6'b000000, 6'b000011};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", {ready, ctrl_valid, illegal, md_start, md_done, md_op, alu_ctrl},
              {1'b1, 4'b0000, 2'b00, 4'b0000});
        @(posedge clk);
        #1;

        issue(2'b10, 6'b101010);
        idle(2);

        issue(2'b00, 6'b111111);
        issue(2'b01, 6'b000101);
        issue(2'b10, 6'b100111);
        idle(2);

        issue(2'b11, 6'b100000);
        issue(2'b10, 6'b000000);
        issue(2'b10, 6'b000011);
        issue(2'b10, 6'b000010);
        issue(2'b10, 6'b110000);
        idle(2);

        run_md(6'b011010, 5);
        idle(1);
        issue(2'b10, 6'b100101);
        run_md(6'b011001, 0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 1) == 1) ? funct_tbl[$urandom_range(0, 7)]
                                            : 6'($urandom_range(0, 63));
            if (f[5:2] == 4'b0110) f = 6'b100000;
            issue(a, f);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        issue(2'b10, 6'b011011);
        valid_in = 1'b0;
        low = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            low++;
        end
        check("busy_before_abort", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", {ready, ctrl_valid, illegal, md_start, md_done, md_op, alu_ctrl},
              {1'b1, 4'b0000, 2'b00, 4'b0000});
        m_alu  = 4'b0000;
        m_mdop = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(MD_CYCLES + 5);
        check("no_done_after_abort", md_done_cnt, exp_done);

        issue(2'b01, 6'b000000);
        idle(3);

        check("scoreboard_empty", exp_q.size(), 0);
        check("md_done_count", md_done_cnt, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
